// File: rtl/bin2bcd_seq_converter.sv
// Serial shift-and-add-3 binary-to-BCD converter: one operand bit per clock, N+1 cycles Start-to-Done.
// Start is taken only when idle; requests and operand changes while Busy are ignored, not queued.
module bin2bcd_seq_converter #(
  parameter int INPUT_BIT_WIDTH = 16,
  parameter int DIGITS          = 5,
  parameter bit SIGNED          = 1'b0
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic [INPUT_BIT_WIDTH-1:0] Input,
  output logic                       Busy,
  output logic                       Done,
  output logic [4*DIGITS-1:0]        Bcd,
  output logic                       Negative,
  output logic                       Overflow
);

  localparam int N  = INPUT_BIT_WIDTH;
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    opnd_q, opnd_d;
  logic [BW-1:0]   dig_q, dig_d;
  logic            sticky_q, sticky_d;
  logic            sign_q, sign_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            neg_q, neg_d;
  logic            ovf_q, ovf_d;

  logic [BW-1:0]   adj;
  logic [BW-1:0]   shifted;
  logic            carry;
  logic            neg_in;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    dig_d    = dig_q;
    sticky_d = sticky_q;
    sign_d   = sign_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    bcd_d    = bcd_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;

    // Per-digit correction; a digit <= 9 plus 3 stays within 4 bits, so no inter-digit carry.
    adj = dig_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = dig_q[4*k +: 4] + 4'd3;
    end
    shifted = {adj[BW-2:0], opnd_q[N-1]};
    carry   = adj[BW-1];
    neg_in  = SIGNED && Input[N-1];

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d  = SHIFT;
          // Two's-complement negate in N bits; -2^(N-1) maps onto 2^(N-1) as unsigned.
          opnd_d   = neg_in ? (~Input) + N'(1) : Input;
          sign_d   = neg_in;
          dig_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = CW'(N);
          busy_d   = 1'b1;
        end
      end
      SHIFT: begin
        dig_d    = shifted;
        opnd_d   = {opnd_q[N-2:0], 1'b0};
        sticky_d = sticky_q | carry;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = shifted;
          neg_d   = sign_q;
          ovf_d   = sticky_q | carry;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opnd_q   <= '0;
      dig_q    <= '0;
      sticky_q <= 1'b0;
      sign_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bcd_q    <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      dig_q    <= dig_d;
      sticky_q <= sticky_d;
      sign_q   <= sign_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bcd_q    <= bcd_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Bcd      = bcd_q;
  assign Negative = neg_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq_converter.sv
// Bench for bin2bcd_seq_converter: five configurations checked against an arithmetic decimal model.
module tb_bin2bcd_seq_converter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  start;
  logic [15:0] in_v [5];

  logic [4:0]  busy_v, done_v, neg_v, ovf_v;
  logic [19:0] bcd_v [5];

  logic [19:0] bcd_a, bcd_c;
  logic [15:0] bcd_b, bcd_d, bcd_e;
  logic        busy_a, busy_b, busy_c, busy_d, busy_e;
  logic        done_a, done_b, done_c, done_d, done_e;
  logic        neg_a, neg_b, neg_c, neg_d, neg_e;
  logic        ovf_a, ovf_b, ovf_c, ovf_d, ovf_e;

  int n_of [5] = '{16, 16, 16, 12, 12};
  int d_of [5] = '{5, 4, 5, 4, 4};
  int s_of [5] = '{0, 0, 1, 0, 1};

  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] prev_done = '0;

  always #5 Clk = ~Clk;

  bin2bcd_seq_converter #(.INPUT_BIT_WIDTH(16), .DIGITS(5), .SIGNED(1'b0)) u_a (
    .Clk(Clk), .Reset(Reset), .Start(start[0]), .Input(in_v[0]), .Busy(busy_a),
    .Done(done_a), .Bcd(bcd_a), .Negative(neg_a), .Overflow(ovf_a));
  bin2bcd_seq_converter #(.INPUT_BIT_WIDTH(16), .DIGITS(4), .SIGNED(1'b0)) u_b (
    .Clk(Clk), .Reset(Reset), .Start(start[1]), .Input(in_v[1]), .Busy(busy_b),
    .Done(done_b), .Bcd(bcd_b), .Negative(neg_b), .Overflow(ovf_b));
  bin2bcd_seq_converter #(.INPUT_BIT_WIDTH(16), .DIGITS(5), .SIGNED(1'b1)) u_c (
    .Clk(Clk), .Reset(Reset), .Start(start[2]), .Input(in_v[2]), .Busy(busy_c),
    .Done(done_c), .Bcd(bcd_c), .Negative(neg_c), .Overflow(ovf_c));
  bin2bcd_seq_converter #(.INPUT_BIT_WIDTH(12), .DIGITS(4), .SIGNED(1'b0)) u_d (
    .Clk(Clk), .Reset(Reset), .Start(start[3]), .Input(in_v[3][11:0]), .Busy(busy_d),
    .Done(done_d), .Bcd(bcd_d), .Negative(neg_d), .Overflow(ovf_d));
  bin2bcd_seq_converter #(.INPUT_BIT_WIDTH(12), .DIGITS(4), .SIGNED(1'b1)) u_e (
    .Clk(Clk), .Reset(Reset), .Start(start[4]), .Input(in_v[4][11:0]), .Busy(busy_e),
    .Done(done_e), .Bcd(bcd_e), .Negative(neg_e), .Overflow(ovf_e));

  always_comb begin
    busy_v   = {busy_e, busy_d, busy_c, busy_b, busy_a};
    done_v   = {done_e, done_d, done_c, done_b, done_a};
    neg_v    = {neg_e, neg_d, neg_c, neg_b, neg_a};
    ovf_v    = {ovf_e, ovf_d, ovf_c, ovf_b, ovf_a};
    bcd_v[0] = bcd_a;
    bcd_v[1] = {4'h0, bcd_b};
    bcd_v[2] = bcd_c;
    bcd_v[3] = {4'h0, bcd_d};
    bcd_v[4] = {4'h0, bcd_e};
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, required %0h", tag, got, exp);
    end
  endtask

  // Decimal reference: magnitude from plain integer arithmetic, digits by repeated /10.
  function automatic logic [19:0] exp_bcd(input int idx, input logic [15:0] v,
                                          output bit neg, output bit ovf);
    longint unsigned raw, m, p;
    logic [19:0] res;
    int n;
    n   = n_of[idx];
    raw = longint'(v) & ((64'd1 << n) - 1);
    neg = (s_of[idx] != 0) && (((raw >> (n - 1)) & 1) == 1);
    m   = neg ? (64'd1 << n) - raw : raw;
    p   = 1;
    for (int k = 0; k < d_of[idx]; k++) p = p * 10;
    ovf = (m >= p);
    m   = m % p;
    res = '0;
    for (int k = 0; k < d_of[idx]; k++) begin
      res[4*k +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return res;
  endfunction

  // Called at a negedge right after Start was raised; returns at the negedge where Done is seen.
  task automatic wait_done(input int idx, input bit hold, output int lat, output int bcy,
                           output bit changed);
    logic [19:0] snap;
    bit got;
    snap = bcd_v[idx];
    got = 0; lat = 0; bcy = 0; changed = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge Clk);
      lat++;
      if (!hold) start[idx] = 1'b0;
      in_v[idx] = 16'($urandom);
      if (busy_v[idx]) bcy++;
      if (done_v[idx]) got = 1;
      else if (bcd_v[idx] !== snap) changed = 1;
    end
    if (!got) check_eq($sformatf("timeout dut%0d", idx), 0, 1);
  endtask

  task automatic check_result(input int idx, input logic [15:0] v, input int lat,
                              input int bcy, input bit ch);
    bit en, eo;
    logic [19:0] eb;
    eb = exp_bcd(idx, v, en, eo);
    check_eq($sformatf("bcd dut%0d in=%0h", idx, v), bcd_v[idx], eb);
    check_eq($sformatf("negative dut%0d in=%0h", idx, v), neg_v[idx], en);
    check_eq($sformatf("overflow dut%0d in=%0h", idx, v), ovf_v[idx], eo);
    check_eq($sformatf("latency dut%0d", idx), lat, n_of[idx] + 1);
    check_eq($sformatf("busy_cycles dut%0d", idx), bcy, n_of[idx]);
    check_eq($sformatf("stable_midconv dut%0d", idx), ch, 0);
  endtask

  task automatic do_conv(input int idx, input logic [15:0] v);
    int lat, bcy;
    bit ch;
    start[idx] = 1'b1;
    in_v[idx]  = v;
    wait_done(idx, 0, lat, bcy, ch);
    check_result(idx, v, lat, bcy, ch);
  endtask

  always @(negedge Clk) begin
    for (int i = 0; i < 5; i++)
      if (done_v[i]) check_eq($sformatf("done_single dut%0d", i), prev_done[i], 0);
    prev_done <= done_v;
  end

  initial begin
    int lat, bcy, ndone;
    bit ch;
    Reset = 1'b1;
    start = '0;
    for (int i = 0; i < 5; i++) in_v[i] = '0;
    repeat (3) @(negedge Clk);
    for (int i = 0; i < 3; i += 2) begin
      check_eq($sformatf("rst_busy dut%0d", i), busy_v[i], 0);
      check_eq($sformatf("rst_done dut%0d", i), done_v[i], 0);
      check_eq($sformatf("rst_bcd dut%0d", i), bcd_v[i], 0);
      check_eq($sformatf("rst_neg dut%0d", i), neg_v[i], 0);
      check_eq($sformatf("rst_ovf dut%0d", i), ovf_v[i], 0);
    end
    Reset = 1'b0;
    @(negedge Clk);

    do_conv(0, 16'd65535);
    do_conv(0, 16'd0);
    do_conv(1, 16'd12345);
    do_conv(1, 16'd9999);
    do_conv(1, 16'd10000);
    do_conv(2, 16'h8000);
    do_conv(2, 16'hFFFF);
    do_conv(2, 16'h0000);
    do_conv(2, 16'h7FFF);

    // Start held high across a conversion, then re-accepted in the Done cycle.
    start[0] = 1'b1;
    in_v[0]  = 16'd1234;
    wait_done(0, 1, lat, bcy, ch);
    check_result(0, 16'd1234, lat, bcy, ch);
    in_v[0] = 16'd5678;
    wait_done(0, 0, lat, bcy, ch);
    check_result(0, 16'd5678, lat, bcy, ch);

    // Reset during the seventh shift cycle aborts silently.
    start[0] = 1'b1;
    in_v[0]  = 16'd40000;
    @(negedge Clk);
    start[0] = 1'b0;
    repeat (6) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check_eq("abort_busy", busy_v[0], 0);
    check_eq("abort_done", done_v[0], 0);
    check_eq("abort_bcd", bcd_v[0], 0);
    check_eq("abort_neg", neg_v[0], 0);
    check_eq("abort_ovf", ovf_v[0], 0);
    Reset = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(negedge Clk);
      if (done_v[0]) ndone++;
    end
    check_eq("abort_no_done", ndone, 0);
    do_conv(0, 16'd255);

    for (int idx = 3; idx < 5; idx++) begin
      do_conv(idx, 16'h000);
      do_conv(idx, 16'hFFF);
      do_conv(idx, 16'h800);
      do_conv(idx, 16'h7FF);
      do_conv(idx, 16'h001);
      for (int r = 0; r < 30; r++) do_conv(idx, 16'($urandom_range(0, 4095)));
    end

    repeat (3) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
